bcedn_frame_sched: RTL and testbench
====================================

// Module: bcedn_frame_sched
// PURPOSE
//  Frame-level sequencer placed in front of BCEDN_TOP. It waits for a frame request and for the accelerator to be ready,
//  then pulses start and streams exactly FRAME_WORDS input words from an upstream valid/ready source into data_in/in_en.
//  Streaming pauses while the accelerator inserts padding (pad hold). The block then waits for done, with a timeout.
//  It counts completed frames and flags protocol and timeout errors.
// PARAMETERS
//  DATA_IN_WIDTH  16     width of source/accelerator input word
//  FRAME_WORDS    1024   input words per frame (>=1)
//  WCNT_W         11     word counter width, must hold FRAME_WORDS
//  TIMEOUT_CYC    65535  max cycles in WAIT_DONE before timeout (>=1)
//  TO_W           16     timeout counter width, must hold TIMEOUT_CYC
//  FCNT_W         16     frame counter width
// PORTS
//  clk          in   1              clock, all logic on rising edge
//  rst          in   1              synchronous, active-low reset
//  frame_req    in   1              request one frame; sampled only in IDLE
//  src_valid    in   1              upstream word valid
//  src_data     in   DATA_IN_WIDTH  upstream word
//  src_ready    out  1              upstream ready (combinational)
//  acc_rdy      in   1              accelerator ready for new frame
//  acc_pad      in   1              accelerator pad insertion active; input stalled
//  acc_done     in   1              accelerator frame done pulse
//  acc_start    out  1              one-cycle start pulse
//  acc_in_en    out  1              input word strobe (registered)
//  acc_data_in  out  DATA_IN_WIDTH  input word (registered; 0 when acc_in_en=0)
//  busy         out  1              1 in any state other than IDLE
//  frame_cnt    out  FCNT_W         completed frames; wraps to 0 after all-ones
//  proto_err    out  1              sticky: acc_done seen during START/STREAM
//  timeout_err  out  1              sticky: done not seen within TIMEOUT_CYC
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE; all outputs 0; word, timeout and frame counters 0; sticky flags cleared.
//  Reset mid-frame aborts immediately. No start or in_en is issued in the cycle after reset.
//  States: IDLE, START, STREAM, WAIT_DONE.
//  IDLE:
//   - frame_req & acc_rdy -> START.
//   - frame_req without acc_rdy waits; the request is not latched, so the requester holds it.
//  START:
//   - acc_start=1 for exactly this one cycle (registered, asserted on entry).
//   - Word counter cleared -> STREAM.
//  STREAM:
//   - src_ready = (state==STREAM) & ~acc_pad. Accept = src_valid & src_ready.
//   - Each accept: next cycle acc_in_en=1, acc_data_in=src_data, word counter +1. Latency is 1 cycle.
//   - No accept: next cycle acc_in_en=0, acc_data_in=0.
//   - acc_pad=1 blocks acceptance in that same cycle; the stalled word stays upstream and nothing is dropped.
//   - Accept of word FRAME_WORDS-1 (the last one) -> WAIT_DONE. Its acc_in_en cycle is the first WAIT_DONE cycle.
//   - Exactly FRAME_WORDS strobes are issued per frame.
//  WAIT_DONE:
//   - src_ready=0. Timeout counter increments each cycle from 0.
//   - acc_done=1 -> IDLE, frame_cnt+1.
//   - Counter reaches TIMEOUT_CYC without done -> timeout_err=1, IDLE, frame_cnt unchanged.
//   - acc_done on the same cycle as the timeout hit: done wins; no error is raised.
//  acc_done in START or STREAM: proto_err=1, abort to IDLE, frame_cnt unchanged, no further strobes. acc_done in IDLE is ignored.
//  Sticky flags clear only on reset. They do not block new frames.
//  acc_pad is ignored outside STREAM. frame_req is ignored when busy=1.
// TESTING
//  1. FRAME_WORDS=4; frame_req=1, acc_rdy=1, src_valid always 1 with data 1,2,3,4.
//     -> acc_start pulses once; then in_en=1 for 4 consecutive cycles carrying 1,2,3,4.
//     -> acc_done 3 cycles later -> IDLE, frame_cnt=1, busy=0.
//  2. Same stream with acc_pad=1 for 2 cycles after word 2.
//     -> src_ready=0 for those 2 cycles and in_en gap of 2 cycles.
//     -> Output still exactly 1,2,3,4 with no duplicate or loss.
//  3. frame_req=1, acc_rdy=0 for 5 cycles then 1.
//     -> No start during the 5 cycles; START occurs on the cycle after acc_rdy rises.
//  4. TIMEOUT_CYC=8; stream all words, never assert done.
//     -> timeout_err=1 after 8 WAIT_DONE cycles, IDLE, frame_cnt unchanged.
//     -> A following frame still completes and increments frame_cnt.
//  5. acc_done pulse after word 2 of 4.
//     -> proto_err=1, IDLE, no further in_en.
//     -> rst=0 mid-STREAM (separately) -> all outputs 0 next cycle.
//  6. FCNT_W=2; run 5 frames -> frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/bcedn_frame_sched.sv
// Frame sequencer in front of BCEDN_TOP: start pulse, FRAME_WORDS-word stream,
// done wait with timeout, completed-frame count and sticky error flags.
module bcedn_frame_sched #(
    parameter int DATA_IN_WIDTH = 16,
    parameter int FRAME_WORDS   = 1024,
    parameter int WCNT_W        = 11,
    parameter int TIMEOUT_CYC   = 65535,
    parameter int TO_W          = 16,
    parameter int FCNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_req,
    input  logic                     src_valid,
    input  logic [DATA_IN_WIDTH-1:0] src_data,
    output logic                     src_ready,
    input  logic                     acc_rdy,
    input  logic                     acc_pad,
    input  logic                     acc_done,
    output logic                     acc_start,
    output logic                     acc_in_en,
    output logic [DATA_IN_WIDTH-1:0] acc_data_in,
    output logic                     busy,
    output logic [FCNT_W-1:0]        frame_cnt,
    output logic                     proto_err,
    output logic                     timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM,
        WAIT_DONE
    } state_t;

    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_WORDS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    state_t                   state_q, state_d;
    logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
    logic [TO_W-1:0]          tcnt_q, tcnt_d;
    logic [FCNT_W-1:0]        fcnt_q, fcnt_d;
    logic                     start_q, start_d;
    logic                     in_en_q, in_en_d;
    logic [DATA_IN_WIDTH-1:0] data_q, data_d;
    logic                     proto_q, proto_d;
    logic                     tmo_q, tmo_d;
    logic                     accept;

    assign src_ready   = (state_q == STREAM) & ~acc_pad;
    assign accept      = src_valid & src_ready;
    assign acc_start   = start_q;
    assign acc_in_en   = in_en_q;
    assign acc_data_in = data_q;
    assign busy        = (state_q != IDLE);
    assign frame_cnt   = fcnt_q;
    assign proto_err   = proto_q;
    assign timeout_err = tmo_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        fcnt_d  = fcnt_q;
        start_d = 1'b0;
        in_en_d = 1'b0;
        data_d  = '0;
        proto_d = proto_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (frame_req & acc_rdy) begin
                    state_d = START;
                    start_d = 1'b1;
                end
            end
            START: begin
                wcnt_d = '0;
                if (acc_done) begin
                    proto_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // An early done aborts; a word taken in the same cycle is discarded.
                if (acc_done) begin
                    proto_d = 1'b1;
                    state_d = IDLE;
                end else if (accept) begin
                    in_en_d = 1'b1;
                    data_d  = src_data;
                    wcnt_d  = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_WORD) begin
                        state_d = WAIT_DONE;
                        tcnt_d  = '0;
                    end
                end
            end
            WAIT_DONE: begin
                tcnt_d = tcnt_q + 1'b1;
                if (acc_done) begin
                    fcnt_d  = fcnt_q + 1'b1;
                    state_d = IDLE;
                end else if (tcnt_q == TO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            fcnt_q  <= '0;
            start_q <= 1'b0;
            in_en_q <= 1'b0;
            data_q  <= '0;
            proto_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            fcnt_q  <= fcnt_d;
            start_q <= start_d;
            in_en_q <= in_en_d;
            data_q  <= data_d;
            proto_q <= proto_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_bcedn_frame_sched.sv
// Randomized frame-level bench for bcedn_frame_sched with a transaction model
// of words in, strobes out, done/timeout/abort outcomes and sticky flags.
module tb_bcedn_frame_sched;

    localparam int DW  = 16;
    localparam int FW  = 4;
    localparam int WCW = 3;
    localparam int TC  = 8;
    localparam int TOW = 4;
    localparam int FCW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_req;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          acc_rdy;
    logic          acc_pad;
    logic          acc_done;
    logic          acc_start;
    logic          acc_in_en;
    logic [DW-1:0] acc_data_in;
    logic          busy;
    logic [FCW-1:0] frame_cnt;
    logic          proto_err;
    logic          timeout_err;

    bcedn_frame_sched #(
        .DATA_IN_WIDTH(DW),
        .FRAME_WORDS  (FW),
        .WCNT_W       (WCW),
        .TIMEOUT_CYC  (TC),
        .TO_W         (TOW),
        .FCNT_W       (FCW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_req  (frame_req),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .acc_rdy    (acc_rdy),
        .acc_pad    (acc_pad),
        .acc_done   (acc_done),
        .acc_start  (acc_start),
        .acc_in_en  (acc_in_en),
        .acc_data_in(acc_data_in),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .proto_err  (proto_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [FCW-1:0] m_fcnt;
    bit             m_proto;
    bit             m_tmo;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags();
        chk("frame_cnt", frame_cnt, m_fcnt);
        chk("proto_err", proto_err, m_proto);
        chk("timeout_err", timeout_err, m_tmo);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, acc_start, 0);
        chk({tag, "_in_en"}, acc_in_en, 0);
        chk({tag, "_data"}, acc_data_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_src_ready"}, src_ready, 0);
        chk({tag, "_fcnt"}, frame_cnt, 0);
        chk({tag, "_proto"}, proto_err, 0);
        chk({tag, "_tmo"}, timeout_err, 0);
    endtask

    // One frame: request held rdy_dly cycles without acc_rdy, stream with the
    // given valid/pad densities, then done on WAIT_DONE cycle done_dly
    // (>= TC means never). abort_at>0 raises done after that many words.
    task automatic run_frame(input int rdy_dly, input int vpct, input int ppct,
                             input int done_dly, input int abort_at);
        logic [DW-1:0] in_w[FW];
        int            nacc;
        int            nstrobe;
        int            cyc;
        bit            acc;
        bit            ab;
        for (int i = 0; i < FW; i++) in_w[i] = DW'($urandom);

        frame_req = 1'b1;
        acc_rdy   = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            acc_done = 1'($urandom_range(0, 1));
            acc_pad  = 1'($urandom_range(0, 1));
            src_valid = 1'b1;
            #1;
            chk("idle_src_ready", src_ready, 0);
            tick();
            chk("idle_start", acc_start, 0);
            chk("idle_busy", busy, 0);
        end
        acc_rdy  = 1'b1;
        acc_done = 1'b0;
        tick();
        chk("start_pulse", acc_start, 1);
        chk("start_busy", busy, 1);

        frame_req = 1'($urandom_range(0, 1));
        acc_rdy   = 1'($urandom_range(0, 1));
        acc_pad   = 1'($urandom_range(0, 1));
        src_valid = 1'b1;
        #1;
        chk("start_src_ready", src_ready, 0);
        tick();
        chk("start_once", acc_start, 0);
        chk("start_no_in_en", acc_in_en, 0);

        nacc    = 0;
        nstrobe = 0;
        cyc     = 0;
        while (nacc < FW) begin
            if (cyc > 300) begin
                chk("stream_bound", nacc, FW);
                break;
            end
            frame_req = 1'($urandom_range(0, 1));
            src_valid = ($urandom_range(0, 99) < vpct);
            src_data  = src_valid ? in_w[nacc] : DW'($urandom);
            acc_pad   = ($urandom_range(0, 99) < ppct);
            ab        = (abort_at > 0) && (nacc == abort_at);
            acc_done  = ab;
            #1;
            chk("src_ready", src_ready, !acc_pad);
            acc = src_valid & !acc_pad;
            tick();
            cyc++;
            if (ab) begin
                acc_done = 1'b0;
                m_proto  = 1'b1;
                chk("abort_in_en", acc_in_en, 0);
                chk("abort_busy", busy, 0);
                for (int k = 0; k < 3; k++) begin
                    frame_req = 1'b0;
                    src_valid = 1'b1;
                    acc_pad   = 1'b0;
                    #1;
                    chk("abort_src_ready", src_ready, 0);
                    tick();
                    chk("abort_no_strobe", acc_in_en, 0);
                    chk("abort_idle", busy, 0);
                end
                chk_flags();
                return;
            end
            chk("in_en", acc_in_en, acc);
            chk("data_in", acc_data_in, acc ? in_w[nacc] : '0);
            if (acc_in_en) nstrobe++;
            if (acc) nacc++;
        end
        chk("strobe_count", nstrobe, FW);

        for (int d = 0; d < TC; d++) begin
            frame_req = 1'($urandom_range(0, 1));
            src_valid = 1'b1;
            acc_pad   = 1'($urandom_range(0, 1));
            acc_done  = (d == done_dly);
            #1;
            chk("wait_src_ready", src_ready, 0);
            chk("wait_busy", busy, 1);
            tick();
            chk("wait_no_strobe", acc_in_en, 0);
            if (d == done_dly) begin
                m_fcnt = m_fcnt + 1'b1;
                chk("done_idle", busy, 0);
                break;
            end
            if (d == TC - 1) begin
                m_tmo = 1'b1;
                chk("timeout_idle", busy, 0);
            end
        end
        acc_done  = 1'b0;
        frame_req = 1'b0;
        acc_rdy   = 1'b0;
        src_valid = 1'b0;
        chk_flags();
    endtask

    task automatic reset_mid();
        frame_req = 1'b1;
        acc_rdy   = 1'b1;
        tick();
        frame_req = 1'b0;
        src_valid = 1'b1;
        acc_pad   = 1'b0;
        tick();
        tick();
        chk("pre_rst_in_en", acc_in_en, 1);
        rst = 1'b0;
        tick();
        rst    = 1'b1;
        m_fcnt = '0;
        m_proto = 1'b0;
        m_tmo  = 1'b0;
        src_valid = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        tick();
        chk("post_rst_start", acc_start, 0);
        chk("post_rst_in_en", acc_in_en, 0);
    endtask

    initial begin
        rst       = 1'b0;
        frame_req = 1'b1;
        src_valid = 1'b1;
        src_data  = 16'h1234;
        acc_rdy   = 1'b1;
        acc_pad   = 1'b0;
        acc_done  = 1'b0;
        m_fcnt    = '0;
        m_proto   = 1'b0;
        m_tmo     = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        frame_req = 1'b0;
        src_valid = 1'b0;
        acc_rdy   = 1'b0;
        rst       = 1'b1;
        tick();
        chk("post_reset_start", acc_start, 0);
        chk("post_reset_in_en", acc_in_en, 0);

        run_frame(0, 100, 0, 2, 0);
        run_frame(0, 100, 40, 1, 0);
        run_frame(5, 100, 0, 0, 0);
        run_frame(0, 100, 0, TC, 0);
        run_frame(0, 100, 0, 1, 0);
        run_frame(0, 100, 0, 0, 2);
        run_frame(0, 70, 20, TC - 1, 0);
        reset_mid();

        for (int f = 0; f < 40; f++) begin
            run_frame($urandom_range(0, 3), $urandom_range(40, 100),
                      $urandom_range(0, 50), $urandom_range(0, TC + 1),
                      ($urandom_range(0, 5) == 0) ? $urandom_range(1, FW - 1) : 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
